full_adder_4bit: RTL and testbench

FULL_ADDER_4BIT -- requirements
Module: full_adder_4bit

---
 rtl/full_adder_4bit_pkg.sv | 6 +
 rtl/full_adder_4bit_full_adder.sv | 13 +
 rtl/full_adder_4bit.sv | 59 +++++
 tb/tb_full_adder_4bit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/full_adder_4bit_pkg.sv
// Shared width constant for the 4-bit ripple-carry adder slice.
package full_adder_4bit_pkg;

    localparam int WIDTH = 4;

endpackage

// File: rtl/full_adder_4bit_full_adder.sv
// One-bit full adder cell; the 4-bit adder chains four of these through its carries.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/full_adder_4bit.sv
// 4-bit ripple-carry adder with combinational sum/carry/overflow and a registered copy.
module full_adder_4bit
    import full_adder_4bit_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic             clk,
    input  logic             rst,
    output logic             ovf,
    output logic [WIDTH-1:0] sum_r,
    output logic             cout_r,
    output logic             ovf_r
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .sum (sum[i]),
            .cout(c[i+1])
        );
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign cout = c[WIDTH];
    assign ovf  = c[WIDTH-1] ^ c[WIDTH];

    assign sum_d  = sum;
    assign cout_d = cout;
    assign ovf_d  = ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign sum_r  = sum_q;
    assign cout_r = cout_q;
    assign ovf_r  = ovf_q;

endmodule

// File: tb/tb_full_adder_4bit.sv
// Self-checking bench for full_adder_4bit: directed vector table, exhaustive sweep, reset corner cases.
module tb_full_adder_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b;
    logic       cin;
    logic [3:0] sum, sumR;
    logic       cout, ovf, coutR, ovfR;

    int compareCount  = 0;
    int mismatchCount = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    full_adder_4bit dut (
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .clk   (clk),
        .rst   (rst),
        .ovf   (ovf),
        .sum_r (sumR),
        .cout_r(coutR),
        .ovf_r (ovfR)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Inputs change on the falling edge so the rising edge always sees settled values.
    task automatic applyStimulus(input logic [3:0] ai, input logic [3:0] bi, input logic ci);
        @(negedge clk);
        a   = ai;
        b   = bi;
        cin = ci;
        #1;
    endtask

    initial begin
        logic [4:0] total;
        logic       expOvf;
        logic [4:0] prevTotal;
        logic       prevOvf;
        logic [3:0] ai, bi;
        logic       ci;

        vecs[0] = '{4'b0000, 4'b0101, 1'b0, 4'b0101, 1'b0, 1'b0};
        vecs[1] = '{4'b0101, 4'b0101, 1'b0, 4'b1010, 1'b0, 1'b1};
        vecs[2] = '{4'b0111, 4'b0011, 1'b0, 4'b1010, 1'b0, 1'b1};
        vecs[3] = '{4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0};
        vecs[4] = '{4'b1111, 4'b0101, 1'b0, 4'b0100, 1'b1, 1'b0};
        vecs[5] = '{4'b1000, 4'b0111, 1'b0, 4'b1111, 1'b0, 1'b0};
        vecs[6] = '{4'b0111, 4'b0111, 1'b1, 4'b1111, 1'b0, 1'b1};
        vecs[7] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
        vecs[8] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[9] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};

        rst = 1'b1;
        a   = 4'b0000;
        b   = 4'b0000;
        cin = 1'b0;
        #2;
        checkOutput("resetSumR", {4'b0, sumR}, 8'h00);
        checkOutput("resetCoutR", {7'b0, coutR}, 8'h00);
        checkOutput("resetOvfR", {7'b0, ovfR}, 8'h00);

        // Combinational path must work while reset is held, and registers must stay cleared.
        applyStimulus(4'b0101, 4'b0101, 1'b0);
        checkOutput("duringResetSum", {4'b0, sum}, 8'h0a);
        checkOutput("duringResetOvf", {7'b0, ovf}, 8'h01);
        @(posedge clk);
        #1;
        checkOutput("heldResetSumR", {4'b0, sumR}, 8'h00);
        checkOutput("heldResetOvfR", {7'b0, ovfR}, 8'h00);

        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
            checkOutput($sformatf("vec%0d.sum", i), {4'b0, sum}, {4'b0, vecs[i].sum});
            checkOutput($sformatf("vec%0d.cout", i), {7'b0, cout}, {7'b0, vecs[i].cout});
            checkOutput($sformatf("vec%0d.ovf", i), {7'b0, ovf}, {7'b0, vecs[i].ovf});
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d.sumR", i), {4'b0, sumR}, {4'b0, vecs[i].sum});
            checkOutput($sformatf("vec%0d.coutR", i), {7'b0, coutR}, {7'b0, vecs[i].cout});
            checkOutput($sformatf("vec%0d.ovfR", i), {7'b0, ovfR}, {7'b0, vecs[i].ovf});
        end

        $display("[TB] exhaustive sweep");
        prevTotal = 5'd0;
        prevOvf   = 1'b0;
        for (int x = 0; x < 512; x++) begin
            {ai, bi, ci} = x[8:0];
            total  = 5'(ai) + 5'(bi) + 5'(ci);
            expOvf = (ai[3] == bi[3]) && (total[3] != ai[3]);
            applyStimulus(ai, bi, ci);
            checkOutput($sformatf("sweep%0d.sum", x), {4'b0, sum}, {4'b0, total[3:0]});
            checkOutput($sformatf("sweep%0d.cout", x), {7'b0, cout}, {7'b0, total[4]});
            checkOutput($sformatf("sweep%0d.ovf", x), {7'b0, ovf}, {7'b0, expOvf});
            if (x > 0) begin
                checkOutput($sformatf("sweep%0d.sumR", x), {4'b0, sumR}, {4'b0, prevTotal[3:0]});
                checkOutput($sformatf("sweep%0d.coutR", x), {7'b0, coutR}, {7'b0, prevTotal[4]});
                checkOutput($sformatf("sweep%0d.ovfR", x), {7'b0, ovfR}, {7'b0, prevOvf});
            end
            prevTotal = total;
            prevOvf   = expOvf;
        end

        $display("[TB] mid-operation reset");
        applyStimulus(4'b1000, 4'b1000, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("preResetSumR", {4'b0, sumR}, 8'h01);
        checkOutput("preResetCoutR", {7'b0, coutR}, 8'h01);
        checkOutput("preResetOvfR", {7'b0, ovfR}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncResetSumR", {4'b0, sumR}, 8'h00);
        checkOutput("asyncResetCoutR", {7'b0, coutR}, 8'h00);
        checkOutput("asyncResetOvfR", {7'b0, ovfR}, 8'h00);
        checkOutput("asyncResetSum", {4'b0, sum}, 8'h01);
        checkOutput("asyncResetCout", {7'b0, cout}, 8'h01);
        checkOutput("asyncResetOvf", {7'b0, ovf}, 8'h01);
        @(posedge clk);
        #1;
        checkOutput("resetEdgeSumR", {4'b0, sumR}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("releaseNoEdgeSumR", {4'b0, sumR}, 8'h00);
        @(posedge clk);
        #1;
        checkOutput("reloadSumR", {4'b0, sumR}, 8'h01);
        checkOutput("reloadCoutR", {7'b0, coutR}, 8'h01);
        checkOutput("reloadOvfR", {7'b0, ovfR}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
